// File: rtl/ex_flag_stage_pkg.sv
// Shared definitions for the EX/MEM flag stage: opcodes, condition codes
// and the N/Z/V flag record.
package ex_flag_stage_pkg;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_XOR    = 4'b0010;
    localparam logic [3:0] OP_RED    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b0111;

    typedef enum logic [2:0] {
        CC_NE  = 3'b000,
        CC_EQ  = 3'b001,
        CC_GT  = 3'b010,
        CC_LT  = 3'b011,
        CC_GE  = 3'b100,
        CC_LE  = 3'b101,
        CC_OV  = 3'b110,
        CC_UNC = 3'b111
    } cc_e;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
    } flags_t;

    // Opcodes with bit 3 set are memory/control instructions, not ALU ops.
    function automatic logic is_alu_op(input logic [3:0] opcode);
        return ~opcode[3];
    endfunction

endpackage

// File: rtl/ex_flag_stage_flag_calc.sv
// Combinational next-flag computation: candidate N/Z/V values for the EX
// instruction plus which of them this opcode is allowed to write.
module ex_flag_stage_flag_calc
    import ex_flag_stage_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             n_next,
    output logic             z_next,
    output logic             v_next,
    output logic             upd_n,
    output logic             upd_z,
    output logic             upd_v
);

    logic [WIDTH-1:0] sum_raw;
    logic [WIDTH-1:0] diff_raw;
    logic             a_sign;
    logic             b_sign;

    // Overflow is judged on the wrapped result even though the ALU saturates.
    assign sum_raw  = op_a + op_b;
    assign diff_raw = op_a - op_b;
    assign a_sign   = op_a[WIDTH-1];
    assign b_sign   = op_b[WIDTH-1];

    always_comb begin
        n_next = alu_result[WIDTH-1];
        z_next = (alu_result == '0);
        v_next = 1'b0;
        upd_n  = 1'b0;
        upd_z  = 1'b0;
        upd_v  = 1'b0;
        if (is_alu_op(opcode)) begin
            case (opcode)
                OP_ADD: begin
                    upd_n  = 1'b1;
                    upd_z  = 1'b1;
                    upd_v  = 1'b1;
                    v_next = (a_sign == b_sign) && (sum_raw[WIDTH-1] != a_sign);
                end
                OP_SUB: begin
                    upd_n  = 1'b1;
                    upd_z  = 1'b1;
                    upd_v  = 1'b1;
                    v_next = (a_sign != b_sign) && (diff_raw[WIDTH-1] != a_sign);
                end
                OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
                    upd_z = 1'b1;
                end
                default: begin
                    upd_n = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ex_flag_stage.sv
// EX/MEM pipeline register with the N/Z/V flag register and the branch
// condition evaluator that decode reads.
module ex_flag_stage
    import ex_flag_stage_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int REGW  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [REGW-1:0]  dst_in,
    input  logic             wr_en_in,
    input  logic             stall,
    input  logic             flush,
    input  logic [2:0]       cond,
    output logic             valid_out,
    output logic [WIDTH-1:0] result_out,
    output logic [REGW-1:0]  dst_out,
    output logic             wr_en_out,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_v,
    output logic             cond_true
);

    // Pipeline control: stall holds every register (valid_out included) and
    // beats flush; flush with no stall inserts a bubble; otherwise the EX
    // instruction moves to MEM. Only an accepted valid instruction may write
    // flags, and wr_en_out is never set for a bubble.
    logic   n_next, z_next, v_next;
    logic   upd_n, upd_z, upd_v;
    logic   accept;
    flags_t flags_q;

    ex_flag_stage_flag_calc #(
        .WIDTH(WIDTH)
    ) u_flag_calc (
        .opcode    (opcode),
        .op_a      (op_a),
        .op_b      (op_b),
        .alu_result(alu_result),
        .n_next    (n_next),
        .z_next    (z_next),
        .v_next    (v_next),
        .upd_n     (upd_n),
        .upd_z     (upd_z),
        .upd_v     (upd_v)
    );

    assign accept = valid_in & ~stall & ~flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_out  <= 1'b0;
            wr_en_out  <= 1'b0;
            result_out <= '0;
            dst_out    <= '0;
        end else if (stall) begin
            valid_out  <= valid_out;
        end else if (flush) begin
            valid_out  <= 1'b0;
            wr_en_out  <= 1'b0;
        end else begin
            valid_out  <= valid_in;
            wr_en_out  <= wr_en_in & valid_in;
            result_out <= alu_result;
            dst_out    <= dst_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else if (accept) begin
            if (upd_n) flags_q.n <= n_next;
            if (upd_z) flags_q.z <= z_next;
            if (upd_v) flags_q.v <= v_next;
        end
    end

    assign flag_n = flags_q.n;
    assign flag_z = flags_q.z;
    assign flag_v = flags_q.v;

    // Reads only the registered flags; a setter still in EX is not forwarded.
    always_comb begin
        cond_true = 1'b0;
        case (cc_e'(cond))
            CC_NE:   cond_true = ~flags_q.z;
            CC_EQ:   cond_true = flags_q.z;
            CC_GT:   cond_true = ~flags_q.z & ~flags_q.n;
            CC_LT:   cond_true = flags_q.n;
            CC_GE:   cond_true = flags_q.z | ~flags_q.n;
            CC_LE:   cond_true = flags_q.n | flags_q.z;
            CC_OV:   cond_true = flags_q.v;
            CC_UNC:  cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: doc/ex_flag_stage.md
Name: ex_flag_stage

Overview:
Execute-to-memory boundary stage placed directly downstream of the 16-bit ALU. It registers the ALU result and destination info into the EX/MEM pipeline register, and computes and holds the N/Z/V condition-flag register according to the opcode. It also evaluates the 3-bit branch condition against the held flags for the decode stage. It supports stall (hold) and flush (bubble) from the hazard unit.

Parameters:
WIDTH, 16, datapath width of operands and result
REGW, 4, register-file index width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
valid_in  in  1  EX-stage instruction is valid
opcode  in  4  full instruction opcode of EX instruction
op_a  in  WIDTH  ALU operand A, used for overflow detection
op_b  in  WIDTH  ALU operand B, used for overflow detection
alu_result  in  WIDTH  saturated ALU result
dst_in  in  REGW  destination register index
wr_en_in  in  1  register write enable of EX instruction
stall  in  1  hold all state this cycle
flush  in  1  replace the EX instruction with a bubble
cond  in  3  branch condition code from decode
valid_out  out  1  MEM-stage instruction valid
result_out  out  WIDTH  registered ALU result
dst_out  out  REGW  registered destination
wr_en_out  out  1  registered write enable, already qualified by valid
flag_n  out  1  negative flag
flag_z  out  1  zero flag
flag_v  out  1  overflow flag
cond_true  out  1  combinational: cond satisfied by current flag register

Behaviour:
- Reset: synchronous on rising clk while rst_n=0. valid_out, result_out, dst_out, wr_en_out, flag_n, flag_z and flag_v all go to 0. Reset overrides stall and flush.
- Latency: 1 cycle. EX inputs sampled at edge k appear on the *_out ports after edge k.
- Opcodes: 0000 ADD, 0001 SUB, 0010 XOR, 0011 RED, 0100 SLL, 0101 SRA, 0110 ROR, 0111 PADDSB. Any opcode with bit 3 = 1 is a non-ALU instruction.
- Flag update rules, applied only when accept = valid_in & ~stall & ~flush:
  - ADD/SUB update N, Z and V.
  - XOR/SLL/SRA/ROR update Z only; N and V hold.
  - RED, PADDSB and non-ALU opcodes leave all flags unchanged.
- Flag computation:
  - Z = (alu_result == 0).
  - N = alu_result[15]. The saturated result carries the true sign.
  - ADD: raw = op_a + op_b, mod 2^16. V = (a15 == b15) & (raw15 != a15).
  - SUB: raw = op_a - op_b, mod 2^16. V = (a15 != b15) & (raw15 != a15).
- Priority: rst_n, then stall, then flush, then normal.
  - stall=1: every register holds, including valid_out, and flags do not update. This applies even if flush=1 at the same time.
  - flush=1 with stall=0: valid_out <= 0 and wr_en_out <= 0. result_out and dst_out load don't-care values, implemented as hold. Flags are not updated.
  - Normal: valid_out <= valid_in; wr_en_out <= wr_en_in & valid_in; result_out and dst_out load their inputs.
- valid_in=0 (bubble): no flag update, and wr_en_out <= 0.
- cond_true is purely combinational from the registered flags. An instruction in EX does not forward its flags; a branch sees the flags one cycle after the setter leaves EX.
  - 000 NE: ~Z
  - 001 EQ: Z
  - 010 GT: ~Z & ~N
  - 011 LT: N
  - 100 GE: Z | ~N
  - 101 LE: N | Z
  - 110 OV: V
  - 111 unconditional: 1
- Reset during stall or flush: reset wins, and all outputs are 0 on the next cycle.

Decomposition:
- Shared package holds:
  - opcode localparams/enum: OP_ADD..OP_PADDSB, plus an alu-op helper checking opcode[3]==0.
  - condition-code enum: CC_NE..CC_UNC.
  - flag struct {n, z, v}.
- One combinational sub-module, flag_calc, takes opcode, op_a, op_b and alu_result. It outputs the next N/Z/V values plus per-flag update enables.
- The pipeline register, flag register and cond mux stay in ex_flag_stage.

Test Plan:
- ADD: op_a=0x7FFF, op_b=0x0001, alu_result=0x7FFF, valid, accepted → next cycle V=1, N=0, Z=0, result_out=0x7FFF; cond=110 gives cond_true=1.
- SUB: op_a=0x1234, op_b=0x1234, alu_result=0 → Z=1, N=0, V=0; cond=001 gives 1, cond=000 gives 0, cond=100 gives 1.
- Flags N=1, V=1 set, then XOR with result 0x0000 → Z=1 with N=1 and V=1 held. A following PADDSB with result 0x0005 leaves Z=1.
- SUB 0x8000-0x0001 (alu_result 0x8000) with stall=1 for 2 cycles → outputs and flags frozen. On release, next cycle V=1, N=1, valid_out=1.
- ADD with result 0 and flush=1 → valid_out=0, wr_en_out=0, flags unchanged. flush=1 together with stall=1 → full hold, valid_out unchanged.
- Load flags Z=1, N=1, V=1, then rst_n=0 for 1 cycle with stall=1 → all outputs 0; cond=111 still gives cond_true=1, cond=011 gives 0.
